// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero count and left-normaliser with valid/ready backpressure.
// Optional exponent adjust path enabled by defining LZC_NORM_EXP_EN.
module lzc_norm_pipe #(
    parameter int W     = 12,
    parameter int CNT_W = $clog2(W + 1)
`ifdef LZC_NORM_EXP_EN
    ,
    parameter int EXP_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     data_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
`ifdef LZC_NORM_EXP_EN
    ,
    input  logic [EXP_W-1:0] exp_i,
    output logic [EXP_W-1:0] exp_o,
    output logic             uf_o
`endif
);

    logic en1;
    logic en2;

    logic             v1_reg;
    logic [W-1:0]     d1_reg;
    logic [CNT_W-1:0] cnt1_reg;
    logic             zero1_reg;

    logic             v2_reg;
    logic [W-1:0]     d2_reg;
    logic [CNT_W-1:0] cnt2_reg;
    logic             zero2_reg;

    logic [W-1:0]     lead;
    logic             zero_next;
    logic [CNT_W-1:0] cnt_next;
    logic [W-1:0]     shift_next;

    assign en2     = !v2_reg || ready_i;
    assign en1     = !v1_reg || en2;
    assign ready_o = en1;

    // Each bit independently decides whether it is the leading one, so the
    // count is a flat one-hot encode rather than a serial priority chain.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lead
            assign lead[gi] = data_i[gi] && !(|(data_i >> (gi + 1)));
        end
    endgenerate

    assign zero_next = !(|data_i);

    always_comb begin
        cnt_next = zero_next ? CNT_W'(W) : '0;
        for (int i = 0; i < W; i++) begin
            if (lead[i]) begin
                cnt_next = cnt_next | CNT_W'(W - 1 - i);
            end
        end
    end

    assign shift_next = d1_reg << cnt1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg    <= 1'b0;
            d1_reg    <= '0;
            cnt1_reg  <= '0;
            zero1_reg <= 1'b0;
        end else if (en1) begin
            v1_reg <= valid_i;
            if (valid_i) begin
                d1_reg    <= data_i;
                cnt1_reg  <= cnt_next;
                zero1_reg <= zero_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            d2_reg    <= '0;
            cnt2_reg  <= '0;
            zero2_reg <= 1'b0;
        end else if (en2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                d2_reg    <= shift_next;
                cnt2_reg  <= cnt1_reg;
                zero2_reg <= zero1_reg;
            end
        end
    end

    assign valid_o = v2_reg;
    assign data_o  = d2_reg;
    assign cnt_o   = cnt2_reg;
    assign zero_o  = zero2_reg;

`ifdef LZC_NORM_EXP_EN
    logic [EXP_W-1:0] exp1_reg;
    logic [EXP_W-1:0] exp2_reg;
    logic             uf2_reg;
    logic [EXP_W:0]   exp_diff;
    logic             uf_next;
    logic [EXP_W-1:0] exp_next;

    // The extra top bit of the difference is the borrow, i.e. exponent < count.
    assign exp_diff = {1'b0, exp1_reg} - (EXP_W + 1)'(cnt1_reg);
    assign uf_next  = exp_diff[EXP_W] || zero1_reg;
    assign exp_next = uf_next ? '0 : exp_diff[EXP_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            exp1_reg <= '0;
        end else if (en1 && valid_i) begin
            exp1_reg <= exp_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp2_reg <= '0;
            uf2_reg  <= 1'b0;
        end else if (en2 && v1_reg) begin
            exp2_reg <= exp_next;
            uf2_reg  <= uf_next;
        end
    end

    assign exp_o = exp2_reg;
    assign uf_o  = uf2_reg;
`endif

endmodule
